// File: rtl/seg_cathode_scan.sv
`default_nettype none
// ============================================================================
//  Module   : seg_cathode_scan
//  Purpose  : Segment-side scan controller for the 7-segment display path.
//             It times each digit slot and pulses rotate to step the external
//             anode ring. It drives active-low segment/dp cathodes for the lit
//             digit, checks the ring pattern fed back and re-seeds the ring
//             after a mismatch.
//  Option   : LEADING_ZERO_BLANK_EN - blank leading zero digits (digit 0 is
//             never blanked).
//  Revision : 1.0 - initial release
// ============================================================================
module seg_cathode_scan #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] digits_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  anode_fb,
  output logic        rotate,
  output logic        shift_rst,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        sync_err
);

  localparam int            CW          = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] c_blank_last = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] c_show_last  = CW'(SCAN_DIV - BLANK_CYC - 3);
  localparam logic [6:0]    c_seg_off    = 7'h7F;

  typedef enum logic [2:0] {
    ST_SEED  = 3'd0,
    ST_BLANK = 3'd1,
    ST_SHOW  = 3'd2,
    ST_STEP  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t          state_q;
  logic [2:0]      idx_q;
  logic [CW-1:0]   cnt_q;
  logic            rotate_q;
  logic            shift_rst_q;
  logic [6:0]      seg_q;
  logic            dp_q;
  logic            sync_err_q;

  logic [3:0]      nib_d;
  logic [6:0]      seg_d;
  logic            dp_d;
  logic [7:0]      fb_exp_d;
  logic            fb_ok_d;

  // Hex nibble to active-low segment code, bit 6 = g .. bit 0 = a.
  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Cathode values for the current digit, and the anode pattern expected
  // for it. These are captured only on the SHOW entry cycle.
  always_comb begin
    nib_d    = digits_in[{idx_q, 2'b00} +: 4];
    seg_d    = hex2seg(nib_d);
`ifdef LEADING_ZERO_BLANK_EN
    // Blank when this nibble and every higher nibble are zero.
    if ((idx_q != 3'd0) && ((digits_in >> {idx_q, 2'b00}) == 32'd0)) begin
      seg_d = c_seg_off;
    end
`endif
    dp_d     = ~dp_in[idx_q];
    fb_exp_d = ~(8'h01 << idx_q);
    fb_ok_d  = (anode_fb == fb_exp_d);
  end

  // Slot sequencer: SEED -> BLANK -> SHOW -> STEP -> GAP -> BLANK ...
  // The cathodes are switched off at the same edge that enters STEP.
  // They stay off until the cycle after SHOW entry, so they are never lit
  // while the ring moves or before the feedback check has passed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_SEED;
      idx_q       <= 3'd0;
      cnt_q       <= '0;
      rotate_q    <= 1'b0;
      shift_rst_q <= 1'b1;
      seg_q       <= c_seg_off;
      dp_q        <= 1'b1;
      sync_err_q  <= 1'b0;
    end else begin
      rotate_q <= 1'b0;
      case (state_q)
        ST_SEED: begin
          idx_q       <= 3'd0;
          seg_q       <= c_seg_off;
          dp_q        <= 1'b1;
          shift_rst_q <= 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q     <= ST_BLANK;
            cnt_q       <= '0;
            shift_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_BLANK: begin
          if (cnt_q == c_blank_last) begin
            state_q <= ST_SHOW;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_SHOW: begin
          if ((cnt_q == '0) && !fb_ok_d) begin
            // The ring is out of step, so drop this slot and re-seed.
            sync_err_q  <= 1'b1;
            state_q     <= ST_SEED;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_rst_q <= 1'b1;
          end else begin
            if (cnt_q == '0) begin
              seg_q <= seg_d;
              dp_q  <= dp_d;
            end
            if (cnt_q == c_show_last) begin
              state_q  <= ST_STEP;
              cnt_q    <= '0;
              rotate_q <= 1'b1;
              seg_q    <= c_seg_off;
              dp_q     <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_STEP: begin
          idx_q   <= idx_q + 3'd1;
          state_q <= ST_GAP;
        end
        ST_GAP: begin
          state_q <= ST_BLANK;
        end
        default: begin
          state_q <= ST_SEED;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign rotate    = rotate_q;
  assign shift_rst = shift_rst_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign sync_err  = sync_err_q;

endmodule
`default_nettype wire
